// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage vs. aux (debug/DMA) requester, fixed-latency DM.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking (default: MEM has priority).
module dmem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [1:0]  aux_size,
    output logic [31:0] aux_rdata,
    output logic        aux_done,
    output logic [31:0] data_address_2DM,
    output logic [31:0] data_write_2DM,
    output logic [1:0]  data_write_size_2DM,
    output logic        MemRead_2DM,
    output logic        MemWrite_2DM,
    input  logic [31:0] data_read_fDM
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
        $error("dmem_arbiter: LATENCY must be within 1..15");
    end

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        gnt_aux_q, gnt_aux_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [31:0] aux_rdata_q, aux_rdata_d;
    logic        mem_done_q, mem_done_d;
    logic        aux_done_q, aux_done_d;
    logic        pick_aux;

`ifdef DMEM_ARB_RR_EN
    logic last_aux_q, last_aux_d;

    // On a tie, whoever was not granted last wins
    assign pick_aux = aux_req && (!mem_req || !last_aux_q);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            last_aux_q <= 1'b1;
        end else begin
            last_aux_q <= last_aux_d;
        end
    end
`else
    assign pick_aux = aux_req && !mem_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        gnt_aux_d   = gnt_aux_q;
        mem_rdata_d = mem_rdata_q;
        aux_rdata_d = aux_rdata_q;
        mem_done_d  = 1'b0;
        aux_done_d  = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_aux_d  = last_aux_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_req || aux_req) begin
                    gnt_aux_d = pick_aux;
                    we_d      = pick_aux ? aux_we    : mem_we;
                    addr_d    = pick_aux ? aux_addr  : mem_addr;
                    wdata_d   = pick_aux ? aux_wdata : mem_wdata;
                    size_d    = pick_aux ? aux_size  : mem_size;
                    cnt_d     = LAT;
                    state_d   = BUSY;
`ifdef DMEM_ARB_RR_EN
                    last_aux_d = pick_aux;
`endif
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (gnt_aux_q) begin
                        aux_done_d = 1'b1;
                        if (!we_q) aux_rdata_d = data_read_fDM;
                    end else begin
                        mem_done_d = 1'b1;
                        if (!we_q) mem_rdata_d = data_read_fDM;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            size_q      <= 2'd0;
            gnt_aux_q   <= 1'b0;
            mem_rdata_q <= 32'd0;
            aux_rdata_q <= 32'd0;
            mem_done_q  <= 1'b0;
            aux_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            gnt_aux_q   <= gnt_aux_d;
            mem_rdata_q <= mem_rdata_d;
            aux_rdata_q <= aux_rdata_d;
            mem_done_q  <= mem_done_d;
            aux_done_q  <= aux_done_d;
        end
    end

    logic busy;
    assign busy = (state_q == BUSY);

    assign data_address_2DM    = busy ? addr_q  : 32'd0;
    assign data_write_2DM      = busy ? wdata_q : 32'd0;
    assign data_write_size_2DM = busy ? size_q  : 2'd0;
    assign MemRead_2DM         = busy && !we_q;
    assign MemWrite_2DM        = busy && we_q;

    assign mem_rdata = mem_rdata_q;
    assign aux_rdata = aux_rdata_q;
    assign mem_done  = mem_done_q;
    assign aux_done  = aux_done_q;
    assign mem_stall = mem_req && !mem_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LATENCY=2 instance plus a LATENCY=1 instance.
// Build with +define+DMEM_ARB_RR_EN to check the round-robin variant.
module tb_dmem_arbiter;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    logic        mem_req = 0, mem_we = 0, aux_req = 0, aux_we = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0, aux_addr = 0, aux_wdata = 0;
    logic [1:0]  mem_size = 0, aux_size = 0;
    logic [31:0] data_read_fDM = 0;

    logic [31:0] mem_rdata, aux_rdata, data_address_2DM, data_write_2DM;
    logic        mem_done, mem_stall, aux_done, MemRead_2DM, MemWrite_2DM;
    logic [1:0]  data_write_size_2DM;

    logic [31:0] d1_mem_rdata, d1_aux_rdata, d1_addr, d1_wdata;
    logic        d1_mem_done, d1_mem_stall, d1_aux_done, d1_rd, d1_wr;
    logic [1:0]  d1_size;

    int vecs = 0;
    int errs = 0;

    dmem_arbiter #(.LATENCY(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_size(aux_size),
        .aux_rdata(aux_rdata), .aux_done(aux_done),
        .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
        .data_write_size_2DM(data_write_size_2DM),
        .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
        .data_read_fDM(data_read_fDM)
    );

    dmem_arbiter #(.LATENCY(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(d1_mem_rdata), .mem_done(d1_mem_done), .mem_stall(d1_mem_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_size(aux_size),
        .aux_rdata(d1_aux_rdata), .aux_done(d1_aux_done),
        .data_address_2DM(d1_addr), .data_write_2DM(d1_wdata),
        .data_write_size_2DM(d1_size),
        .MemRead_2DM(d1_rd), .MemWrite_2DM(d1_wr),
        .data_read_fDM(data_read_fDM)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        tick();
        tick();
        vecs++; if (mem_rdata !== 32'd0) begin errs++; $display("FAIL rst_mem_rdata: got %h want 0", mem_rdata); end
        vecs++; if (aux_rdata !== 32'd0) begin errs++; $display("FAIL rst_aux_rdata: got %h want 0", aux_rdata); end
        vecs++; if ({mem_done, aux_done, mem_stall} !== 3'b000) begin errs++; $display("FAIL rst_flags: got %b want 000", {mem_done, aux_done, mem_stall}); end
        vecs++; if ({MemRead_2DM, MemWrite_2DM, data_write_size_2DM} !== 4'd0) begin errs++; $display("FAIL rst_dm_ctl: got %b want 0000", {MemRead_2DM, MemWrite_2DM, data_write_size_2DM}); end
        vecs++; if ({data_address_2DM, data_write_2DM} !== 64'd0) begin errs++; $display("FAIL rst_dm_bus: got %h want 0", {data_address_2DM, data_write_2DM}); end
        vecs++; if ({d1_mem_done, d1_rd, d1_wr, d1_mem_rdata} !== 35'd0) begin errs++; $display("FAIL rst_dut1: got %h want 0", {d1_mem_done, d1_rd, d1_wr, d1_mem_rdata}); end
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_mem_load;
        mem_we = 0; mem_addr = 32'h100; mem_size = 2'd0;
        data_read_fDM = 32'hDEADBEEF;
        mem_req = 1;
        #1;
        vecs++; if (mem_stall !== 1'b1) begin errs++; $display("FAIL load_stall_T: got %b want 1", mem_stall); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            vecs++; if ({MemRead_2DM, MemWrite_2DM} !== 2'b10) begin errs++; $display("FAIL load_rdwr_T%0d: got %b want 10", i, {MemRead_2DM, MemWrite_2DM}); end
            vecs++; if (data_address_2DM !== 32'h100) begin errs++; $display("FAIL load_addr_T%0d: got %h want 100", i, data_address_2DM); end
            vecs++; if ({mem_stall, mem_done} !== 2'b10) begin errs++; $display("FAIL load_stall_done_T%0d: got %b want 10", i, {mem_stall, mem_done}); end
        end
        tick();
        vecs++; if ({mem_done, aux_done, mem_stall} !== 3'b100) begin errs++; $display("FAIL load_done: got %b want 100", {mem_done, aux_done, mem_stall}); end
        vecs++; if ({MemRead_2DM, MemWrite_2DM} !== 2'b00) begin errs++; $display("FAIL load_done_rdwr: got %b want 00", {MemRead_2DM, MemWrite_2DM}); end
        vecs++; if (mem_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL load_rdata: got %h want deadbeef", mem_rdata); end
        vecs++; if (aux_rdata !== 32'd0) begin errs++; $display("FAIL load_aux_rdata: got %h want 0", aux_rdata); end
        mem_req = 0;
        tick();
        vecs++; if ({mem_done, MemRead_2DM} !== 2'b00) begin errs++; $display("FAIL load_after: got %b want 00", {mem_done, MemRead_2DM}); end
        vecs++; if (data_address_2DM !== 32'd0) begin errs++; $display("FAIL load_idle_addr: got %h want 0", data_address_2DM); end
    endtask

    task automatic test_aux_store;
        aux_we = 1; aux_addr = 32'h40; aux_wdata = 32'h12345678; aux_size = 2'd1;
        data_read_fDM = 32'hCAFEF00D;
        aux_req = 1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            vecs++; if ({MemRead_2DM, MemWrite_2DM} !== 2'b01) begin errs++; $display("FAIL st_rdwr_T%0d: got %b want 01", i, {MemRead_2DM, MemWrite_2DM}); end
            vecs++; if (data_write_2DM !== 32'h12345678) begin errs++; $display("FAIL st_wdata_T%0d: got %h want 12345678", i, data_write_2DM); end
            vecs++; if (data_write_size_2DM !== 2'd1) begin errs++; $display("FAIL st_size_T%0d: got %0d want 1", i, data_write_size_2DM); end
            vecs++; if (data_address_2DM !== 32'h40) begin errs++; $display("FAIL st_addr_T%0d: got %h want 40", i, data_address_2DM); end
        end
        tick();
        vecs++; if ({aux_done, mem_done, MemWrite_2DM} !== 3'b100) begin errs++; $display("FAIL st_done: got %b want 100", {aux_done, mem_done, MemWrite_2DM}); end
        vecs++; if (aux_rdata !== 32'd0) begin errs++; $display("FAIL st_aux_rdata: got %h want 0", aux_rdata); end
        vecs++; if (mem_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL st_mem_rdata: got %h want deadbeef", mem_rdata); end
        aux_req = 0; aux_we = 0;
        tick();
        vecs++; if (aux_done !== 1'b0) begin errs++; $display("FAIL st_after: got %b want 0", aux_done); end
    endtask

    task automatic test_addr_change;
        mem_we = 0; mem_addr = 32'h100; mem_req = 1;
        tick();
        mem_addr = 32'h200; mem_we = 1;
        #1;
        vecs++; if (data_address_2DM !== 32'h100) begin errs++; $display("FAIL chg_addr_T1: got %h want 100", data_address_2DM); end
        vecs++; if ({MemRead_2DM, MemWrite_2DM} !== 2'b10) begin errs++; $display("FAIL chg_rdwr_T1: got %b want 10", {MemRead_2DM, MemWrite_2DM}); end
        tick();
        vecs++; if (data_address_2DM !== 32'h100) begin errs++; $display("FAIL chg_addr_T2: got %h want 100", data_address_2DM); end
        tick();
        vecs++; if (mem_done !== 1'b1) begin errs++; $display("FAIL chg_done: got %b want 1", mem_done); end
        mem_req = 0; mem_we = 0; mem_addr = 32'h100;
        tick();
    endtask

    task automatic test_arbitration;
        logic exp_aux;
        RESET = 0;
        tick();
        RESET = 1;
        mem_we = 0; aux_we = 0; data_read_fDM = 32'h55AA55AA;
        mem_req = 1; aux_req = 1;
        for (int k = 0; k < 4; k++) begin
            repeat (3) tick();
`ifdef DMEM_ARB_RR_EN
            exp_aux = (k % 2) == 1;
`else
            exp_aux = 1'b0;
`endif
            vecs++; if ({mem_done, aux_done} !== {!exp_aux, exp_aux}) begin errs++; $display("FAIL arb_grant%0d: got %b want %b", k, {mem_done, aux_done}, {!exp_aux, exp_aux}); end
            if (k == 3) begin
                mem_req = 0; aux_req = 0;
            end
            tick();
        end
    endtask

    task automatic test_reset_busy;
        mem_we = 0; mem_addr = 32'h80; data_read_fDM = 32'h11111111;
        mem_req = 1;
        tick();
        tick();
        RESET = 0;
        tick();
        vecs++; if ({mem_done, aux_done, MemRead_2DM, MemWrite_2DM} !== 4'd0) begin errs++; $display("FAIL rb_flags: got %b want 0000", {mem_done, aux_done, MemRead_2DM, MemWrite_2DM}); end
        vecs++; if ({data_address_2DM, mem_rdata, aux_rdata} !== 96'd0) begin errs++; $display("FAIL rb_buses: got %h want 0", {data_address_2DM, mem_rdata, aux_rdata}); end
        RESET = 1;
        data_read_fDM = 32'h0BADCAFE;
        tick();
        vecs++; if ({mem_done, MemRead_2DM} !== 2'b01) begin errs++; $display("FAIL rb_regrant: got %b want 01", {mem_done, MemRead_2DM}); end
        tick();
        tick();
        vecs++; if (mem_done !== 1'b1) begin errs++; $display("FAIL rb_done: got %b want 1", mem_done); end
        vecs++; if (mem_rdata !== 32'h0BADCAFE) begin errs++; $display("FAIL rb_rdata: got %h want 0badcafe", mem_rdata); end
        mem_req = 0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic exp_rd, exp_done;
        RESET = 0;
        tick();
        RESET = 1;
        mem_we = 0; mem_addr = 32'h300;
        data_read_fDM = 32'hA0000000;
        mem_req = 1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            data_read_fDM = 32'hA0000000 | c;
            exp_rd = (c % 3 == 1) && (c <= 8);
            exp_done = (c % 3 == 2);
            vecs++; if ({d1_rd, d1_mem_done} !== {exp_rd, exp_done}) begin errs++; $display("FAIL b2b_c%0d: rd/done got %b want %b", c, {d1_rd, d1_mem_done}, {exp_rd, exp_done}); end
            if (exp_done) begin
                vecs++; if (d1_mem_rdata !== (32'hA0000000 | (c - 1))) begin errs++; $display("FAIL b2b_rdata_c%0d: got %h want %h", c, d1_mem_rdata, 32'hA0000000 | (c - 1)); end
            end
            if (c == 8) mem_req = 0;
        end
    endtask

    initial begin
        test_reset();
        test_mem_load();
        test_aux_store();
        test_addr_change();
        test_arbitration();
        test_reset_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: cycles the data memory needs per access, measured from the first cycle a request is driven to the cycle read data is valid.
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  in  1  reset; synchronous, active-low.
REQ-004 mem_req, mem_we  in  1 each  MEM-stage access request and write flag (1=store, 0=load).
REQ-005 mem_addr, mem_wdata  in  32 each; mem_size  in  2  (0=word, 1=byte, 2=half, 3=three bytes).
REQ-006 mem_rdata  out  32; mem_done  out  1; mem_stall  out  1  pipeline stall request.
REQ-007 aux_req, aux_we  in  1 each; aux_addr, aux_wdata  in  32 each; aux_size  in  2  secondary requester (debug/DMA), same encoding.
REQ-008 aux_rdata  out  32; aux_done  out  1.
REQ-009 data_address_2DM  out  32; data_write_2DM  out  32; data_write_size_2DM  out  2; MemRead_2DM, MemWrite_2DM  out  1 each; data_read_fDM  in  32.

Function
REQ-010 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-011 IDLE: on any req=1, the block SHALL grant one requester, latch its we/addr/wdata/size into internal registers, load the counter with LATENCY, and go to BUSY next cycle.
REQ-012 Tie in IDLE (both req=1): arbitration SHALL follow REQ-030/031.
REQ-013 BUSY: the DM outputs SHALL present the latched fields; MemRead_2DM = !we and MemWrite_2DM = we; the counter decrements each cycle.
REQ-014 Last BUSY cycle (counter=1): the block SHALL register data_read_fDM into the granted requester's rdata (loads only) and go to DONE.
REQ-015 DONE: exactly one cycle; the granted done output =1 and MemRead_2DM = MemWrite_2DM = 0; the next state is IDLE.
REQ-016 Latency: request sampled in cycle T -> DM driven in T+1..T+LATENCY -> done=1 in T+LATENCY+1; the next grant is possible no earlier than T+LATENCY+2.
REQ-017 Requesters SHALL hold req until done; req seen in the DONE cycle is not a new request; arbitration resumes in IDLE.
REQ-018 Input field changes after grant SHALL be ignored; a req deasserted before grant SHALL cause no access.
REQ-019 rdata of the non-granted requester SHALL keep its previous value; store completions SHALL leave rdata unchanged.
REQ-020 mem_stall SHALL equal mem_req AND NOT mem_done (combinational).
REQ-021 In IDLE, all DM outputs SHALL be 0.
REQ-022 The counter SHALL be 4 bits wide; LATENCY outside 1..15 SHALL raise an elaboration error.

Reset
REQ-023 While RESET=0 at a clock edge: state <= IDLE, counter <= 0, latched fields <= 0, mem_rdata and aux_rdata <= 0, done outputs <= 0, round-robin pointer <= "AUX last".
REQ-024 Reset during BUSY or DONE SHALL abort the access with no done pulse; the DM outputs are 0 from the cycle after the reset edge.

Configuration
REQ-030 With DMEM_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins; the pointer updates on each grant.
REQ-031 Without DMEM_ARB_RR_EN: fixed priority; MEM always wins a tie; no pointer register is present.

Verification
REQ-040 LATENCY=2, mem load of addr 0x100, data_read_fDM=0xDEADBEEF -> MemRead_2DM=1 for 2 cycles, mem_done=1 in cycle T+3, mem_rdata=0xDEADBEEF, mem_stall=1 for T..T+2.
REQ-041 aux store of addr 0x40, wdata 0x12345678, size 1 -> data_write_2DM=0x12345678, data_write_size_2DM=1, MemWrite_2DM=1 for LATENCY cycles, aux_done pulse, aux_rdata unchanged.
REQ-042 Both requesting continuously, RR build -> grants alternate MEM, AUX, MEM, AUX; non-RR build -> MEM only, with AUX starved while mem_req=1.
REQ-043 Change mem_addr from 0x100 to 0x200 during BUSY -> data_address_2DM stays 0x100.
REQ-044 RESET=0 in the second BUSY cycle -> no done pulse; all outputs 0; the next request is serviced normally.
REQ-045 LATENCY=1 back-to-back mem loads -> done every 3rd cycle; the req seen in the DONE cycle is not double-serviced.
